// File: rtl/datamem_ctrl.sv
// Data-memory controller: decodes core load/store requests onto SDRAM, frame buffer or GPIO,
// extracts byte/half load lanes, and guarantees every request ends with opFinish (opErr on fault).
module datamem_ctrl #(
  parameter logic [7:0] SDRAM_BASE = 8'h80,
  parameter logic [7:0] FB_BASE    = 8'h20,
  parameter logic [7:0] IO_BASE    = 8'h10,
  parameter int         NUM_GPIO   = 4,
  parameter int         GPIO_W     = 8,
  parameter int         FB_RD_LAT  = 1,
  parameter int         TIMEOUT    = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                data,
  input  logic [31:0]                addr,
  input  logic                       memRead,
  input  logic                       memWrite,
  input  logic [2:0]                 memSignWidth,
  output logic                       initFinish,
  output logic                       op,
  output logic                       opFinish,
  output logic                       opErr,
  output logic [31:0]                dataOut,
  output logic                       sdram_enable,
  output logic                       sdram_write,
  output logic [23:0]                sdram_addr,
  output logic [31:0]                sdram_wdata,
  output logic [1:0]                 sdram_dwidth,
  input  logic [31:0]                sdram_rdata,
  input  logic                       sdram_ready,
  output logic [NUM_GPIO*GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0]          gpio_in,
  output logic                       fb_we,
  output logic                       fb_re,
  output logic [1:0]                 fb_mask,
  output logic [15:0]                fb_addr,
  output logic [31:0]                fb_wdata,
  input  logic [31:0]                fb_rdata
);

  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_IDLE    = 4'd1;
  localparam logic [3:0] S_IO      = 4'd2;
  localparam logic [3:0] S_FB_REQ  = 4'd3;
  localparam logic [3:0] S_FB_WAIT = 4'd4;
  localparam logic [3:0] S_SD_REQ  = 4'd5;
  localparam logic [3:0] S_SD_WAIT = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;
  localparam logic [3:0] S_FAULT   = 4'd9;

  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    FB_LAST  = 3'(FB_RD_LAT - 1);

  logic [3:0]        state;
  logic [TW-1:0]     tmo_cnt;
  logic [2:0]        fb_cnt;
  logic [GPIO_W-1:0] gpio_q [NUM_GPIO];
  logic [GPIO_W-1:0] gpio_sel;
  logic [31:0]       io_rd;
  logic [7:0]        io_idx;
  logic              io_hit;
  logic [1:0]        width;
  logic              misaligned;

  assign width      = memSignWidth[1:0];
  assign misaligned = (width == 2'b11) || (width == 2'b01 && addr[0]) ||
                      (width == 2'b10 && addr[1:0] != 2'b00);
  assign io_idx     = addr[7:0];
  assign io_hit     = 32'(io_idx) < NUM_GPIO;

  assign op           = memRead | memWrite;
  assign opFinish     = (state == S_DONE) || (state == S_ERR);
  assign opErr        = (state == S_ERR);
  assign sdram_enable = (state == S_SD_REQ);
  assign sdram_write  = (state == S_SD_REQ) && memWrite;
  assign sdram_addr   = addr[23:0];
  assign sdram_wdata  = data;
  assign sdram_dwidth = width;
  assign fb_we        = (state == S_FB_REQ) && memWrite;
  assign fb_re        = (state == S_FB_REQ) && !memWrite;
  assign fb_mask      = width;
  assign fb_addr      = addr[15:0];
  assign fb_wdata     = data;

  for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio
    assign gpio_out[g*GPIO_W +: GPIO_W] = gpio_q[g];
  end

  // GPIO reads are index-addressed, so they return the whole zero-extended register with no lane shift.
  always_comb begin
    gpio_sel = '0;
    for (int i = 0; i < NUM_GPIO; i++)
      if (io_idx == 8'(i)) gpio_sel = gpio_q[i];
    io_rd = '0;
    if (io_hit) io_rd[GPIO_W-1:0] = gpio_sel;
    else        io_rd[GPIO_W-1:0] = gpio_in;
  end

  function automatic logic [31:0] extract(input logic [31:0] raw, input logic [1:0] w,
                                          input logic [1:0] lane, input logic zx);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = '0;
    res = raw;
    case (w)
      2'b00: begin
        sh  = raw >> {lane, 3'b000};
        res = zx ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh  = raw >> {lane[1], 4'b0000};
        res = zx ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: res = raw;
    endcase
    return res;
  endfunction

  // Decode faults pass through S_FAULT so they complete with the same latency as an IO access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      initFinish <= 1'b0;
      dataOut    <= '0;
      tmo_cnt    <= '0;
      fb_cnt     <= '0;
      for (int i = 0; i < NUM_GPIO; i++) gpio_q[i] <= '0;
    end else begin
      case (state)
        S_INIT: if (sdram_ready) begin
          initFinish <= 1'b1;
          state      <= S_IDLE;
        end
        S_IDLE: begin
          tmo_cnt <= '0;
          fb_cnt  <= '0;
          if (op) begin
            if (misaligned)                 state <= S_FAULT;
            else if (addr[31:24] == SDRAM_BASE) state <= S_SD_REQ;
            else if (addr[31:24] == FB_BASE)    state <= S_FB_REQ;
            else if (addr[31:24] == IO_BASE)    state <= S_IO;
            else                                state <= S_FAULT;
          end
        end
        S_FAULT: begin
          dataOut <= '0;
          state   <= S_ERR;
        end
        S_IO: begin
          if (io_hit) begin
            if (memWrite) begin
              for (int i = 0; i < NUM_GPIO; i++)
                if (io_idx == 8'(i)) gpio_q[i] <= data[GPIO_W-1:0];
            end else begin
              dataOut <= io_rd;
            end
            state <= S_DONE;
          end else if (io_idx == 8'hFF && !memWrite) begin
            dataOut <= io_rd;
            state   <= S_DONE;
          end else begin
            dataOut <= '0;
            state   <= S_ERR;
          end
        end
        S_FB_REQ: state <= S_FB_WAIT;
        S_FB_WAIT: begin
          if (memWrite) begin
            state <= S_DONE;
          end else if (fb_cnt == FB_LAST) begin
            dataOut <= extract(fb_rdata, width, addr[1:0], memSignWidth[2]);
            state   <= S_DONE;
          end else begin
            fb_cnt <= fb_cnt + 3'd1;
          end
        end
        // One timeout counter spans request and wait so a stuck SDRAM cannot stall the core.
        S_SD_REQ, S_SD_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (state == S_SD_REQ && !sdram_ready) begin
            state <= S_SD_WAIT;
          end else if (state == S_SD_WAIT && sdram_ready) begin
            if (!memWrite) dataOut <= extract(sdram_rdata, width, addr[1:0], memSignWidth[2]);
            state <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            dataOut <= '0;
            state   <= S_ERR;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_ctrl.sv
// Directed self-checking bench for datamem_ctrl: reset, GPIO, SDRAM and frame-buffer accesses,
// alignment/unmapped faults, SDRAM timeout and reset in mid-access.
module tb_datamem_ctrl;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data, addr;
  logic        memRead, memWrite;
  logic [2:0]  memSignWidth;
  logic        initFinish, op, opFinish, opErr;
  logic [31:0] dataOut;
  logic        sdram_enable, sdram_write;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_wdata;
  logic [1:0]  sdram_dwidth;
  logic [31:0] sdram_rdata;
  logic        sdram_ready;
  logic [31:0] gpio_out;
  logic [7:0]  gpio_in;
  logic        fb_we, fb_re;
  logic [1:0]  fb_mask;
  logic [15:0] fb_addr;
  logic [31:0] fb_wdata, fb_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  datamem_ctrl #(
    .SDRAM_BASE(8'h80), .FB_BASE(8'h20), .IO_BASE(8'h10),
    .NUM_GPIO(4), .GPIO_W(8), .FB_RD_LAT(1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .addr(addr),
    .memRead(memRead), .memWrite(memWrite), .memSignWidth(memSignWidth),
    .initFinish(initFinish), .op(op), .opFinish(opFinish), .opErr(opErr), .dataOut(dataOut),
    .sdram_enable(sdram_enable), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
    .sdram_wdata(sdram_wdata), .sdram_dwidth(sdram_dwidth), .sdram_rdata(sdram_rdata),
    .sdram_ready(sdram_ready), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .fb_we(fb_we), .fb_re(fb_re), .fb_mask(fb_mask), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] sw,
                           input logic [31:0] a, input logic [31:0] d);
    memRead = rd; memWrite = wr; memSignWidth = sw; addr = a; data = d;
  endtask

  // Drop the request and let DONE/ERR return to IDLE.
  task automatic idle_gap();
    memRead = 1'b0; memWrite = 1'b0;
    @(posedge clk); #1;
  endtask

  // Counts sampled edges until opFinish; -1 if the budget expires.
  task automatic wait_finish(input int budget, output int cycles);
    bit done = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      cycles++;
      done = opFinish;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sdram_ready = 1'b1;
    drive_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({initFinish, opFinish, opErr, op} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_status: got %b expected 0000", {initFinish, opFinish, opErr, op});
    end
    tests_run++;
    if ({sdram_enable, sdram_write, fb_we, fb_re} !== 4'b0000) begin
      tests_failed++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {sdram_enable, sdram_write, fb_we, fb_re});
    end
    tests_run++;
    if (dataOut !== 32'h0 || gpio_out !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_data: dataOut %h gpio_out %h expected 0", dataOut, gpio_out);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (initFinish !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL init_finish: got %b expected 1", initFinish);
    end
  endtask

  task automatic test_gpio();
    int cyc;
    drive_req(1'b0, 1'b1, 3'b100, 32'h1000_0002, 32'h0000_00A5);
    #1;
    tests_run++;
    if (op !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL op_comb: got %b expected 1", op);
    end
    wait_finish(10, cyc);
    tests_run++;
    if (cyc != 2 || opErr !== 1'b0 || gpio_out !== 32'h00A5_0000) begin
      tests_failed++; $display("[TB] FAIL gpio_write: cyc %0d opErr %b gpio_out %h expected 2 0 00a50000", cyc, opErr, gpio_out);
    end
    idle_gap();
    drive_req(1'b1, 1'b0, 3'b101, 32'h1000_0002, 32'h0);
    wait_finish(10, cyc);
    tests_run++;
    if (cyc != 2 || opErr !== 1'b0 || dataOut !== 32'h0000_00A5) begin
      tests_failed++; $display("[TB] FAIL gpio_read: cyc %0d opErr %b dataOut %h expected 2 0 000000a5", cyc, opErr, dataOut);
    end
    idle_gap();
    gpio_in = 8'h3C;
    drive_req(1'b1, 1'b0, 3'b100, 32'h1000_00FF, 32'h0);
    wait_finish(10, cyc);
    tests_run++;
    if (opErr !== 1'b0 || dataOut !== 32'h0000_003C) begin
      tests_failed++; $display("[TB] FAIL gpio_in_read: opErr %b dataOut %h expected 0 0000003c", opErr, dataOut);
    end
    idle_gap();
    drive_req(1'b0, 1'b1, 3'b100, 32'h1000_00FF, 32'h0000_0077);
    wait_finish(10, cyc);
    tests_run++;
    if (cyc != 2 || opErr !== 1'b1 || gpio_out !== 32'h00A5_0000) begin
      tests_failed++; $display("[TB] FAIL gpio_in_write_err: cyc %0d opErr %b gpio_out %h expected 2 1 00a50000", cyc, opErr, gpio_out);
    end
    idle_gap();
    drive_req(1'b1, 1'b0, 3'b100, 32'h1000_0004, 32'h0);
    wait_finish(10, cyc);
    tests_run++;
    if (opErr !== 1'b1 || dataOut !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL gpio_bad_index: opErr %b dataOut %h expected 1 0", opErr, dataOut);
    end
    idle_gap();
    drive_req(1'b1, 1'b1, 3'b100, 32'h1000_0001, 32'h0000_0133);
    wait_finish(10, cyc);
    tests_run++;
    if (opErr !== 1'b0 || gpio_out !== 32'h00A5_3300) begin
      tests_failed++; $display("[TB] FAIL gpio_rw_is_write: opErr %b gpio_out %h expected 0 00a53300", opErr, gpio_out);
    end
    idle_gap();
  endtask

  task automatic test_sdram_load();
    logic [2:0]  sw  [2] = '{3'b000, 3'b101};
    logic [31:0] ad  [2] = '{32'h8000_0003, 32'h8000_0002};
    logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_80FF};
    for (int v = 0; v < 2; v++) begin
      sdram_ready = 1'b1;
      drive_req(1'b1, 1'b0, sw[v], ad[v], 32'h0);
      @(posedge clk); #1;
      tests_run++;
      if (sdram_enable !== 1'b1 || sdram_write !== 1'b0 || sdram_addr !== ad[v][23:0] || sdram_dwidth !== sw[v][1:0]) begin
        tests_failed++; $display("[TB] FAIL sd_req_%0d: en %b wr %b addr %h dw %b", v, sdram_enable, sdram_write, sdram_addr, sdram_dwidth);
      end
      sdram_ready = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (sdram_enable !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL sd_accept_%0d: sdram_enable %b expected 0", v, sdram_enable);
      end
      @(posedge clk); #1;
      sdram_rdata = 32'h80FF_0000; sdram_ready = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (opFinish !== 1'b1 || opErr !== 1'b0 || dataOut !== exp[v]) begin
        tests_failed++; $display("[TB] FAIL sd_load_%0d: fin %b err %b dataOut %h expected 1 0 %h", v, opFinish, opErr, dataOut, exp[v]);
      end
      idle_gap();
    end
    drive_req(1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D);
    @(posedge clk); #1;
    tests_run++;
    if (sdram_write !== 1'b1 || sdram_wdata !== 32'hCAFE_F00D) begin
      tests_failed++; $display("[TB] FAIL sd_store_req: wr %b wdata %h expected 1 cafef00d", sdram_write, sdram_wdata);
    end
    sdram_ready = 1'b0;
    @(posedge clk); #1;
    sdram_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (opFinish !== 1'b1 || opErr !== 1'b0 || dataOut !== 32'h0000_80FF) begin
      tests_failed++; $display("[TB] FAIL sd_store_done: fin %b err %b dataOut %h expected 1 0 000080ff", opFinish, opErr, dataOut);
    end
    idle_gap();
  endtask

  task automatic test_misaligned();
    bit saw_en = 1'b0;
    int cyc;
    logic [2:0]  sw [2] = '{3'b011, 3'b001};
    logic [31:0] ad [2] = '{32'h2000_0000, 32'h1000_0001};
    drive_req(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0);
    @(posedge clk); #1;
    saw_en = sdram_enable;
    tests_run++;
    if (opFinish !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL misalign_early: opFinish %b expected 0", opFinish);
    end
    @(posedge clk); #1;
    saw_en = saw_en | sdram_enable;
    tests_run++;
    if (opFinish !== 1'b1 || opErr !== 1'b1 || dataOut !== 32'h0 || saw_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL misalign_word: fin %b err %b dataOut %h saw_en %b expected 1 1 0 0", opFinish, opErr, dataOut, saw_en);
    end
    idle_gap();
    for (int v = 0; v < 2; v++) begin
      drive_req(1'b1, 1'b0, sw[v], ad[v], 32'h0);
      wait_finish(10, cyc);
      tests_run++;
      if (cyc != 2 || opErr !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL width_err_%0d: cyc %0d opErr %b expected 2 1", v, cyc, opErr);
      end
      idle_gap();
    end
  endtask

  task automatic test_unmapped();
    int cyc;
    drive_req(1'b1, 1'b0, 3'b010, 32'h4000_0000, 32'h0);
    wait_finish(10, cyc);
    tests_run++;
    if (cyc != 2 || opErr !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL unmapped: cyc %0d opErr %b expected 2 1", cyc, opErr);
    end
    idle_gap();
  endtask

  task automatic test_fb();
    int cyc;
    fb_rdata = 32'hDEAD_DEAD;
    drive_req(1'b1, 1'b0, 3'b000, 32'h2000_0001, 32'h0);
    @(posedge clk); #1;
    tests_run++;
    if (fb_re !== 1'b1 || fb_we !== 1'b0 || fb_addr !== 16'h0001 || fb_mask !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL fb_rd_req: re %b we %b addr %h mask %b", fb_re, fb_we, fb_addr, fb_mask);
    end
    @(posedge clk); #1;
    tests_run++;
    if (fb_re !== 1'b0 || opFinish !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL fb_re_pulse: re %b fin %b expected 0 0", fb_re, opFinish);
    end
    fb_rdata = 32'h1234_F678;
    @(posedge clk); #1;
    fb_rdata = 32'hDEAD_DEAD;
    tests_run++;
    if (opFinish !== 1'b1 || opErr !== 1'b0 || dataOut !== 32'hFFFF_FFF6) begin
      tests_failed++; $display("[TB] FAIL fb_read: fin %b err %b dataOut %h expected 1 0 fffffff6", opFinish, opErr, dataOut);
    end
    idle_gap();
    drive_req(1'b0, 1'b1, 3'b001, 32'h2000_0004, 32'h0000_BEEF);
    @(posedge clk); #1;
    tests_run++;
    if (fb_we !== 1'b1 || fb_re !== 1'b0 || fb_wdata !== 32'h0000_BEEF || fb_mask !== 2'b01 || fb_addr !== 16'h0004) begin
      tests_failed++; $display("[TB] FAIL fb_wr_req: we %b re %b wdata %h mask %b addr %h", fb_we, fb_re, fb_wdata, fb_mask, fb_addr);
    end
    wait_finish(10, cyc);
    tests_run++;
    if (cyc != 2 || opErr !== 1'b0 || dataOut !== 32'hFFFF_FFF6) begin
      tests_failed++; $display("[TB] FAIL fb_write: cyc %0d err %b dataOut %h expected 2 0 fffffff6", cyc, opErr, dataOut);
    end
    idle_gap();
  endtask

  task automatic test_timeout();
    int cyc;
    sdram_ready = 1'b1;
    drive_req(1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0);
    @(posedge clk); #1;
    tests_run++;
    if (sdram_enable !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL tmo_enable: got %b expected 1", sdram_enable);
    end
    wait_finish(TIMEOUT + 20, cyc);
    tests_run++;
    if (cyc != TIMEOUT || opErr !== 1'b1 || sdram_enable !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL timeout: cyc %0d err %b en %b expected %0d 1 0", cyc, opErr, sdram_enable, TIMEOUT);
    end
    idle_gap();
  endtask

  task automatic test_reset_midop();
    bit saw_fin = 1'b0;
    drive_req(1'b1, 1'b0, 3'b010, 32'h2000_0000, 32'h0);
    @(posedge clk); #1;
    tests_run++;
    if (fb_re !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midop_re: got %b expected 1", fb_re);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (fb_re !== 1'b0 || opFinish !== 1'b0 || gpio_out !== 32'h0 || initFinish !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midop_reset: re %b fin %b gpio %h init %b expected 0", fb_re, opFinish, gpio_out, initFinish);
    end
    memRead = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      saw_fin = saw_fin | opFinish;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      saw_fin = saw_fin | opFinish;
    end
    tests_run++;
    if (saw_fin !== 1'b0 || initFinish !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midop_no_finish: saw_fin %b init %b expected 0 1", saw_fin, initFinish);
    end
  endtask

  initial begin
    sdram_rdata = 32'h0; gpio_in = 8'h00; fb_rdata = 32'h0;
    test_reset();
    test_gpio();
    test_sdram_load();
    test_misaligned();
    test_unmapped();
    test_fb();
    test_timeout();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
